// File: rtl/score_digitizer_if.sv
// Controller/renderer bus for score_digitizer: sampled score/lives in, BCD digits out.
// Handshake: no back-pressure. srtFrm is a 1-cycle request that is accepted only while busy=0;
// digVld is a 1-cycle strobe marking new digits, which then hold until the next strobe.
interface score_digitizer_if #(
    parameter int SCR_W = 10
);
    logic             srtFrm;
    logic [SCR_W-1:0] scrNum;
    logic [1:0]       scrLiv;
    logic [3:0]       digOne;
    logic [3:0]       digTen;
    logic [3:0]       digHun;
    logic [3:0]       digTho;
    logic [1:0]       livDig;
    logic             busy;
    logic             digVld;
    logic [1:0]       fsmState;

    modport master (
        output srtFrm, scrNum, scrLiv,
        input  digOne, digTen, digHun, digTho, livDig, busy, digVld, fsmState
    );

    modport slave (
        input  srtFrm, scrNum, scrLiv,
        output digOne, digTen, digHun, digTho, livDig, busy, digVld, fsmState
    );
endinterface

// File: rtl/score_digitizer.sv
// Frame-sampled iterative double-dabble score/lives digitizer.
// Define SCORE_BLANK_EN for leading-zero blanking (4'hF glyph); default outputs raw BCD.
module score_digitizer #(
    parameter int SCR_W = 10,
    parameter int DIG_N = 4
) (
    input  logic               clk,
    input  logic               reset,
    score_digitizer_if.slave   bus
);
    localparam int BCD_W = 4 * DIG_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_start;
    logic               w_last_step;

    logic [SCR_W-1:0]   binReg;
    logic [BCD_W-1:0]   bcdReg;
    logic [SCR_W-1:0]   lastScr;
    logic [1:0]         lastLiv;
    logic [1:0]         livReg;
    logic [3:0]         cnt;
    logic               frcUpd;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [3:0]         w_one, w_ten, w_hun, w_tho;

    logic [3:0]         r_digOne, r_digTen, r_digHun, r_digTho;
    logic [1:0]         r_livDig;
    logic               r_digVld;

    assign w_start = (r_state == IDLE) && bus.srtFrm &&
                     (frcUpd || (bus.scrNum != lastScr) || (bus.scrLiv != lastLiv));
    assign w_last_step = (cnt == 4'(SCR_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = SHIFT;
            SHIFT:   if (w_last_step) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction is judged on the pre-shift nibbles.
    always_comb begin
        w_bcd_adj = bcdReg;
        for (int i = 0; i < DIG_N; i++) begin
            if (bcdReg[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            binReg  <= '0;
            bcdReg  <= '0;
            lastScr <= '0;
            lastLiv <= '0;
            livReg  <= '0;
            cnt     <= '0;
            frcUpd  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        binReg  <= bus.scrNum;
                        livReg  <= bus.scrLiv;
                        lastScr <= bus.scrNum;
                        lastLiv <= bus.scrLiv;
                        bcdReg  <= '0;
                        cnt     <= '0;
                        frcUpd  <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcdReg <= {w_bcd_adj[BCD_W-2:0], binReg[SCR_W-1]};
                    binReg <= {binReg[SCR_W-2:0], 1'b0};
                    cnt    <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_BLANK_EN
    always_comb begin
        w_one = bcdReg[3:0];
        w_ten = bcdReg[7:4];
        w_hun = bcdReg[11:8];
        w_tho = bcdReg[15:12];
        if (bcdReg[15:12] == 4'd0) begin
            w_tho = 4'hF;
            if (bcdReg[11:8] == 4'd0) begin
                w_hun = 4'hF;
                if (bcdReg[7:4] == 4'd0) w_ten = 4'hF;
            end
        end
    end
`else
    always_comb begin
        w_one = bcdReg[3:0];
        w_ten = bcdReg[7:4];
        w_hun = bcdReg[11:8];
        w_tho = bcdReg[15:12];
    end
`endif

    // Outputs only move at the DONE edge so the renderer never sees partial results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digOne <= '0;
            r_digTen <= '0;
            r_digHun <= '0;
            r_digTho <= '0;
            r_livDig <= '0;
            r_digVld <= 1'b0;
        end else begin
            r_digVld <= 1'b0;
            if (r_state == DONE) begin
                r_digOne <= w_one;
                r_digTen <= w_ten;
                r_digHun <= w_hun;
                r_digTho <= w_tho;
                r_livDig <= livReg;
                r_digVld <= 1'b1;
            end
        end
    end

    assign bus.digOne   = r_digOne;
    assign bus.digTen   = r_digTen;
    assign bus.digHun   = r_digHun;
    assign bus.digTho   = r_digTho;
    assign bus.livDig   = r_livDig;
    assign bus.digVld   = r_digVld;
    assign bus.busy     = (r_state != IDLE);
    assign bus.fsmState = r_state;
endmodule

// File: tb/tb_score_digitizer.sv
// Scoreboard bench for score_digitizer: directed frames push expected digits, a monitor pops on digVld.
module tb_score_digitizer;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [17:0] exp_q[$];

    score_digitizer_if #(.SCR_W(10)) bus ();

    score_digitizer #(.SCR_W(10), .DIG_N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] blank(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef SCORE_BLANK_EN
        if (d[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (d[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (d[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [15:0] dec(input int v);
        logic [15:0] d;
        d[15:12] = 4'((v / 1000) % 10);
        d[11:8]  = 4'((v / 100) % 10);
        d[7:4]   = 4'((v / 10) % 10);
        d[3:0]   = 4'(v % 10);
        return d;
    endfunction

    // monitor
    always @(negedge clk) begin
        if (!reset && bus.digVld) begin
            logic [17:0] act;
            act = {bus.digTho, bus.digHun, bus.digTen, bus.digOne, bus.livDig};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_digvld: got %0h expected no publish", act);
            end else begin
                chk("digits", 32'(act), 32'(exp_q.pop_front()));
            end
`ifdef SCORE_BLANK_EN
            chk("tho_range", 32'(bus.digTho == 4'd1 || bus.digTho == 4'hF), 32'd1);
`else
            chk("tho_range", 32'(bus.digTho <= 4'd1), 32'd1);
`endif
        end
    end

    // driver: one frame; E0 is the edge that samples srtFrm
    task automatic frame(input logic [9:0] v, input logic [1:0] l, input bit conv,
                         input logic [15:0] exp_dig, input bit timing);
        int busy_n, vld_n, lat;
        busy_n = 0; vld_n = 0; lat = 0;
        @(negedge clk);
        bus.srtFrm = 1'b1;
        bus.scrNum = v;
        bus.scrLiv = l;
        if (conv) exp_q.push_back({blank(exp_dig), l});
        @(posedge clk);
        #1 bus.srtFrm = 1'b0;
        if (bus.busy) busy_n++;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_n++;
            if (bus.digVld) begin vld_n++; lat = k; end
        end
        if (conv) begin
            chk("vld_count", 32'(vld_n), 32'd1);
            if (timing) begin
                chk("latency", 32'(lat), 32'd11);
                chk("busy_cycles", 32'(busy_n), 32'd11);
            end
        end else begin
            chk("no_vld", 32'(vld_n), 32'd0);
            chk("no_busy", 32'(busy_n), 32'd0);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_digits"}, 32'({bus.digTho, bus.digHun, bus.digTen, bus.digOne, bus.livDig}), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_vld"}, 32'(bus.digVld), 32'd0);
        chk({tag, "_state"}, 32'(bus.fsmState), 32'd0);
    endtask

    initial begin
        bus.srtFrm = 1'b0;
        bus.scrNum = '0;
        bus.scrLiv = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // reset during a conversion of 777, after E4
        @(negedge clk);
        bus.srtFrm = 1'b1;
        bus.scrNum = 10'd777;
        @(posedge clk);
        #1 bus.srtFrm = 1'b0;
        chk("busy_777", 32'(bus.busy), 32'd1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;

        // forced update after reset even with scrNum=0 / scrLiv=0 unchanged from reset values
        frame(10'd0, 2'd0, 1'b1, 16'h0000, 1'b1);
        frame(10'd1023, 2'd3, 1'b1, 16'h1023, 1'b1);
        frame(10'd5, 2'd3, 1'b1, 16'h0005, 1'b1);
        frame(10'd5, 2'd3, 1'b0, 16'h0005, 1'b0);
        frame(10'd5, 2'd2, 1'b1, 16'h0005, 1'b1);

        // second srtFrm at E5 with 45 is ignored while busy
        begin
            int vld_n;
            vld_n = 0;
            @(negedge clk);
            bus.srtFrm = 1'b1;
            bus.scrNum = 10'd40;
            bus.scrLiv = 2'd1;
            exp_q.push_back({blank(16'h0040), 2'd1});
            @(posedge clk);
            #1 bus.srtFrm = 1'b0;
            for (int k = 1; k < 20; k++) begin
                if (k == 5) begin
                    bus.srtFrm = 1'b1;
                    bus.scrNum = 10'd45;
                end
                @(posedge clk);
                #1 bus.srtFrm = 1'b0;
                if (bus.digVld) vld_n++;
            end
            chk("overlap_single_vld", 32'(vld_n), 32'd1);
        end
        frame(10'd45, 2'd1, 1'b1, 16'h0045, 1'b1);

        frame(10'd100, 2'd1, 1'b1, 16'h0100, 1'b1);
        frame(10'd7, 2'd1, 1'b1, 16'h0007, 1'b1);

        for (int i = 0; i < 1024; i++)
            frame(10'(i), 2'(i), 1'b1, dec(i), 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1);
    end
endmodule
